// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the level-tracking FIFO.
package fifo_pkg;

    localparam int default_data_width = 32;
    localparam int default_depth      = 16;

    function automatic int fifo_addr_bits(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int fifo_level_bits(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array: one synchronous write port, one asynchronous read port.
module fifo_ram #(
    parameter int data_width = 32,
    parameter int depth      = 16,
    parameter int addr_bits  = 4
) (
    input  logic                  clk,
    input  logic                  write_strobe,
    input  logic [addr_bits-1:0]  write_addr,
    input  logic [data_width-1:0] write_data,
    input  logic [addr_bits-1:0]  read_addr,
    output logic [data_width-1:0] read_data
);

    logic [data_width-1:0] mem [depth];

    always_ff @(posedge clk) begin
        if (write_strobe) begin
            mem[write_addr] <= write_data;
        end
    end

    assign read_data = mem[read_addr];

endmodule

// File: rtl/fifo_level.sv
// Synchronous fall-through FIFO of any depth >= 2 with level, thresholds,
// guarded accept logic, synchronous flush and sticky error flags.
module fifo_level
    import fifo_pkg::*;
#(
    parameter int data_width         = default_data_width,
    parameter int depth              = default_depth,
    parameter int almost_full_level  = 12,
    parameter int almost_empty_level = 2
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              flush,
    input  logic                              write_enable,
    input  logic [data_width-1:0]             write_data,
    input  logic                              read_enable,
    output logic [data_width-1:0]             read_data,
    output logic                              empty,
    output logic                              full,
    output logic                              almost_empty,
    output logic                              almost_full,
    output logic [fifo_level_bits(depth)-1:0] level,
    output logic                              overflow,
    output logic                              underflow,
    input  logic                              clear_errors
);

    localparam int addr_bits  = fifo_addr_bits(depth);
    localparam int level_bits = fifo_level_bits(depth);

    typedef logic [addr_bits-1:0]  ptr_t;
    typedef logic [level_bits-1:0] level_t;

    ptr_t   wr_ptr;
    ptr_t   rd_ptr;
    level_t level_q;
    logic   rd_ok;
    logic   wr_ok;
    logic   wr_reject;
    logic   rd_reject;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(depth - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    assign rd_ok     = read_enable & ~empty;
    assign wr_ok     = write_enable & (~full | rd_ok);
    // Requests made while flushing are dropped silently.
    assign wr_reject = ~flush & write_enable & ~wr_ok;
    assign rd_reject = ~flush & read_enable & ~rd_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({wr_ok, rd_ok})
                2'b10:   level_q <= level_q + level_t'(1);
                2'b01:   level_q <= level_q - level_t'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // A new error in the same cycle as clear_errors keeps the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wr_reject | (overflow & ~clear_errors);
            underflow <= rd_reject | (underflow & ~clear_errors);
        end
    end

    fifo_ram #(
        .data_width (data_width),
        .depth      (depth),
        .addr_bits  (addr_bits)
    ) u_ram (
        .clk          (clk),
        .write_strobe (wr_ok & ~flush),
        .write_addr   (wr_ptr),
        .write_data   (write_data),
        .read_addr    (rd_ptr),
        .read_data    (read_data)
    );

    assign level        = level_q;
    assign empty        = (level_q == '0);
    assign full         = (level_q == level_t'(depth));
    assign almost_empty = (level_q <= level_t'(almost_empty_level));
    assign almost_full  = (level_q >= level_t'(almost_full_level));

endmodule

// File: tb/tb_fifo_level.sv
// Bench for fifo_level at depth 5: vector table, directed corner cases and
// random traffic against a queue-based reference model.
module tb_fifo_level;

    localparam int DW    = 8;
    localparam int DEPTH = 5;
    localparam int AF    = 4;
    localparam int AE    = 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          flush, write_enable, read_enable, clear_errors;
    logic [DW-1:0] write_data;
    logic [DW-1:0] read_data;
    logic          empty, full, almost_empty, almost_full, overflow, underflow;
    logic [2:0]    level;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] q[$];
    logic          m_ovf, m_unf;

    always #5 clk = ~clk;

    fifo_level #(
        .data_width         (DW),
        .depth              (DEPTH),
        .almost_full_level  (AF),
        .almost_empty_level (AE)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (flush),
        .write_enable (write_enable),
        .write_data   (write_data),
        .read_enable  (read_enable),
        .read_data    (read_data),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .level        (level),
        .overflow     (overflow),
        .underflow    (underflow),
        .clear_errors (clear_errors)
    );

    typedef struct {
        logic          f, we, re, clr;
        logic [DW-1:0] wd;
        int            lvl;
        logic          ovf, unf;
        int            head;
    } vec_t;

    vec_t tv[13];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        int n;
        n = q.size();
        chk({tag, ".level"}, int'(level), n);
        chk({tag, ".empty"}, int'(empty), int'(n == 0));
        chk({tag, ".full"}, int'(full), int'(n == DEPTH));
        chk({tag, ".almost_empty"}, int'(almost_empty), int'(n <= AE));
        chk({tag, ".almost_full"}, int'(almost_full), int'(n >= AF));
        chk({tag, ".overflow"}, int'(overflow), int'(m_ovf));
        chk({tag, ".underflow"}, int'(underflow), int'(m_unf));
        if (n > 0) chk({tag, ".read_data"}, int'(read_data), int'(q[0]));
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // Reference behaviour: a word is accepted if there is room now or the head
    // leaves in the same cycle; a pop needs a stored word.
    task automatic model_clock(input logic f, we, re, clr, input logic [DW-1:0] wd);
        bit can_rd, can_wr;
        can_rd = re && (q.size() > 0);
        can_wr = we && ((q.size() < DEPTH) || can_rd);
        if (clr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (f) begin
            q.delete();
        end else begin
            if (we && !can_wr) m_ovf = 1'b1;
            if (re && !can_rd) m_unf = 1'b1;
            if (can_rd) void'(q.pop_front());
            if (can_wr) q.push_back(wd);
        end
    endtask

    task automatic step(input string tag, input logic f, we, re, clr, input logic [DW-1:0] wd);
        flush        = f;
        write_enable = we;
        read_enable  = re;
        clear_errors = clr;
        write_data   = wd;
        @(posedge clk);
        model_clock(f, we, re, clr, wd);
        #1;
        check_model(tag);
        flush        = 1'b0;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        clear_errors = 1'b0;
    endtask

    initial begin
        reset_n      = 1'b0;
        flush        = 1'b0;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        clear_errors = 1'b0;
        write_data   = '0;
        model_reset();
        #12;
        check_model("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Fill to full, overflow, drain, underflow, clear.
        tv[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 1, 1'b0, 1'b0, 1};
        tv[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 2, 1'b0, 1'b0, 1};
        tv[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd3, 3, 1'b0, 1'b0, 1};
        tv[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd4, 4, 1'b0, 1'b0, 1};
        tv[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd5, 5, 1'b0, 1'b0, 1};
        tv[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd6, 5, 1'b1, 1'b0, 1};
        tv[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 4, 1'b1, 1'b0, 2};
        tv[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 3, 1'b1, 1'b0, 3};
        tv[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 2, 1'b1, 1'b0, 4};
        tv[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1, 1'b1, 1'b0, 5};
        tv[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 0, 1'b1, 1'b0, -1};
        tv[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 0, 1'b1, 1'b1, -1};
        tv[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 0, 1'b0, 1'b0, -1};
        for (int i = 0; i < 13; i++) begin
            step("tv", tv[i].f, tv[i].we, tv[i].re, tv[i].clr, tv[i].wd);
            chk($sformatf("tv%0d.level", i), int'(level), tv[i].lvl);
            chk($sformatf("tv%0d.overflow", i), int'(overflow), int'(tv[i].ovf));
            chk($sformatf("tv%0d.underflow", i), int'(underflow), int'(tv[i].unf));
            chk($sformatf("tv%0d.full", i), int'(full), int'(tv[i].lvl == DEPTH));
            chk($sformatf("tv%0d.almost_full", i), int'(almost_full), int'(tv[i].lvl >= 4));
            if (tv[i].head >= 0) chk($sformatf("tv%0d.head", i), int'(read_data), tv[i].head);
        end

        // Wrap: 12 write/read pairs walk the pointers around a depth of 5 twice.
        for (int k = 0; k < 12; k++) begin
            step("wrap_w", 1'b0, 1'b1, 1'b0, 1'b0, 8'(8'h40 + k));
            chk("wrap.head", int'(read_data), 8'h40 + k);
            step("wrap_r", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        end
        chk("wrap.level", int'(level), 0);

        // Full with simultaneous write and read.
        for (int k = 0; k < 5; k++) step("fill", 1'b0, 1'b1, 1'b0, 1'b0, 8'(8'h10 + k));
        step("full_rw", 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5);
        chk("full_rw.level", int'(level), 5);
        chk("full_rw.overflow", int'(overflow), 0);
        chk("full_rw.head", int'(read_data), 8'h11);
        for (int k = 0; k < 5; k++) step("drain", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

        // Empty with simultaneous write and read: no bypass.
        step("empty_rw", 1'b0, 1'b1, 1'b1, 1'b0, 8'h3C);
        chk("empty_rw.underflow", int'(underflow), 1);
        chk("empty_rw.level", int'(level), 1);
        chk("empty_rw.head", int'(read_data), 8'h3C);
        step("clr", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);

        // Flush with a write pending, then clear racing a new underflow.
        step("pre_flush", 1'b0, 1'b1, 1'b0, 1'b0, 8'h21);
        step("pre_flush", 1'b0, 1'b1, 1'b0, 1'b0, 8'h22);
        chk("pre_flush.level", int'(level), 3);
        step("flush", 1'b1, 1'b1, 1'b0, 1'b0, 8'h77);
        chk("flush.level", int'(level), 0);
        chk("flush.overflow", int'(overflow), 0);
        step("flush_rd", 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("flush_rd.underflow", int'(underflow), 0);
        step("unf", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        step("clr_race", 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        chk("clr_race.underflow", int'(underflow), 1);
        step("clr", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            step("rand", 1'(($urandom_range(0, 31) == 0)),
                 1'(($urandom_range(0, 99) < 55)),
                 1'(($urandom_range(0, 99) < 45)),
                 1'(($urandom_range(0, 15) == 0)),
                 8'($urandom));
        end

        // Asynchronous reset mid-stream with level 5 and a flag set.
        step("pre_rst", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        for (int k = 0; k < 6; k++) step("pre_rst", 1'b0, 1'b1, 1'b0, 1'b0, 8'(8'h60 + k));
        chk("pre_rst.level", int'(level), 5);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_model("async_rst");
        chk("async_rst.level", int'(level), 0);
        chk("async_rst.empty", int'(empty), 1);
        chk("async_rst.overflow", int'(overflow), 0);
        @(negedge clk);
        reset_n = 1'b1;
        step("post_rst", 1'b0, 1'b1, 1'b0, 1'b0, 8'h99);
        chk("post_rst.head", int'(read_data), 8'h99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
